neighbor_req_issuer: RTL and testbench
======================================

Name: neighbor_req_issuer

Overview:
- Request-side producer for the neighbor-list SRAM path.
- Collects neighbor-fetch requests from the `Num_Edge_PE` edge PEs and arbitrates among them round-robin.
- Splits each request into chunks of at most 31 neighbors.
- Writes each chunk into the neighbor FIFO as a Neighbor_info2Neighbor_FIFO word, honouring `wfull` backpressure.
- Drives the `wdata`/`wfull` interface of S_Neighbor_SRAM_integration.

Parameters:
- NUM_PE, default `Num_Edge_PE` (4): number of requesting edge PEs.
- TAG_W, default $clog2(NUM_PE) (2): width of the PE_tag field.
- CNT_W, default 8: width of the requested neighbor count.
- MAX_CHUNK, default 31: maximum length per FIFO word; fixed by the 5-bit len field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PE  per-PE request strobe.
- req_bank  in  NUM_PE x 2  per-PE SRAM bank.
- req_addr  in  NUM_PE x 10  per-PE neighbor-list base address.
- req_cnt  in  NUM_PE x CNT_W  per-PE total neighbor count.
- req_ready  out  NUM_PE  per-PE slot free.
- req_done  out  NUM_PE  one-cycle pulse when a PE's last chunk is written.
- wdata  out  Neighbor_info2Neighbor_FIFO  {valid, addr = {bank[1:0], addr[9:0], len[4:0]}, PE_tag[TAG_W-1:0]}.
- wfull  in  1  FIFO full; no write may occur while high.

Behaviour:
- One holding slot per PE with state IDLE/ACTIVE. Slot registers: bank, cur_addr (10 b), remaining (CNT_W).
- `req_ready[i]` = (slot i IDLE), taken from registered state.
- Capture: a handshake occurs on a rising edge with `req_valid[i]` & `req_ready[i]`.
  - cnt > 0: slot goes ACTIVE with bank, addr, cnt loaded.
  - cnt == 0: slot stays IDLE, no FIFO word is written, and `req_done[i]` pulses in the next cycle.
- Output word: `wdata` is combinational from registered state (no extra pipeline stage).
  - Selected slot g = first ACTIVE slot at or after `rr_ptr`, searching in increasing index with wrap.
  - `wdata.valid` = (any slot ACTIVE) & ~`wfull`.
  - Fields: bank, cur_addr, len = min(remaining, MAX_CHUNK), PE_tag = g.
  - When `wdata.valid` = 0, all `wdata` fields are driven 0.
- Write commit: a rising edge with `wdata.valid` = 1 counts as one FIFO write.
  - cur_addr += len, mod 1024, wrapping within the same bank; no carry into bank.
  - remaining -= len.
  - `rr_ptr` = g + 1 mod NUM_PE. Interleaving is per chunk, not per request.
  - If remaining becomes 0: slot goes IDLE and `req_done[g]` pulses for exactly the following cycle.
- Latency: capture at edge T, first word valid during cycle T+1 if the slot wins and `wfull` = 0. A request of n neighbors needs ceil(n/31) writes.
- `wfull` high: `wdata.valid` = 0, no slot, pointer or address changes, and requests are still captured into IDLE slots. Writing resumes in the same cycle `wfull` deasserts.
- Simultaneous events:
  - Capture into IDLE slots and a write from an ACTIVE slot occur in the same edge independently.
  - A slot finishing at edge T shows ready in cycle T+1; no same-edge re-accept.
- Reset low (asynchronous, any time, including mid-request):
  - All slots IDLE, `rr_ptr` = 0, `req_done` = 0, `wdata` = 0; `req_ready` reads all-ones.
  - In-flight chunks are discarded, with no partial write.
- `req_*` inputs of a slot are ignored while that slot is ACTIVE.

Test Plan:
- Single short request: PE0 {bank 0, addr 0, cnt 5} -> one write {valid 1, addr {00, 0, 5}, PE_tag 0} in cycle T+1; `req_done[0]` pulses next cycle.
- Chunking: PE1 {bank 1, addr 2, cnt 70} -> three writes in order: {01, 2, 31}, {01, 33, 31}, {01, 64, 8}, all with tag 1; done only after the third.
- Address wrap: PE2 {bank 3, addr 1020, cnt 40} -> writes {11, 1020, 31}, then {11, 27, 9}; bank stays 3.
- Round-robin with backpressure: PE0 cnt 62 and PE3 cnt 31 both captured, `wfull` held high 4 cycles -> no writes during the stall; after release, tags written in order 0, 3, 0.
- Zero count: PE1 cnt 0 -> no FIFO write; `req_done[1]` pulses one cycle after capture; `req_ready[1]` stays 1.
- Reset mid-request: PE0 cnt 100, reset asserted after the first write -> `wdata` drops to 0 immediately; after release, `req_ready` = 1111 and no residual writes occur.

Source files
------------

// File: rtl/neighbor_req_issuer.sv
// Neighbor-list request issuer: per-PE holding slots, round-robin chunk selection,
// and at most one 31-neighbor word written into the neighbor FIFO per cycle.
module neighbor_req_issuer #(
    parameter int NUM_PE    = 4,
    parameter int TAG_W     = $clog2(NUM_PE),
    parameter int CNT_W     = 8,
    parameter int MAX_CHUNK = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PE-1:0]             req_valid,
    input  logic [NUM_PE-1:0][1:0]        req_bank,
    input  logic [NUM_PE-1:0][9:0]        req_addr,
    input  logic [NUM_PE-1:0][CNT_W-1:0]  req_cnt,
    output logic [NUM_PE-1:0]             req_ready,
    output logic [NUM_PE-1:0]             req_done,
    output logic [TAG_W+17:0]             wdata,
    input  logic                          wfull
);

    logic [NUM_PE-1:0]             active;
    logic [TAG_W-1:0]              rr_ptr;
    logic [NUM_PE-1:0][1:0]        bank_q;
    logic [NUM_PE-1:0][9:0]        addr_q;
    logic [NUM_PE-1:0][CNT_W-1:0]  rem_q;

    logic             sel_found;
    logic [TAG_W-1:0] sel;
    logic [TAG_W-1:0] sel_next;
    logic [4:0]       sel_len;
    logic             wr;

    function automatic logic [4:0] chunk_len(input logic [CNT_W-1:0] rem);
        if (int'(rem) > MAX_CHUNK)
            return 5'(MAX_CHUNK);
        else
            return 5'(rem);
    endfunction

    assign req_ready = ~active;

    // First ACTIVE slot at or after rr_ptr, wrapping around the PE index space.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_PE;
            if (!sel_found && active[idx]) begin
                sel_found = 1'b1;
                sel       = TAG_W'(idx);
            end
        end
    end

    assign sel_len  = chunk_len(rem_q[sel]);
    assign sel_next = (int'(sel) == NUM_PE - 1) ? '0 : sel + 1'b1;
    assign wr       = sel_found & ~wfull;
    assign wdata    = wr ? {1'b1, bank_q[sel], addr_q[sel], sel_len, sel} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active   <= '0;
            rr_ptr   <= '0;
            req_done <= '0;
        end else begin
            req_done <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                if (!active[i] && req_valid[i]) begin
                    if (req_cnt[i] != '0)
                        active[i] <= 1'b1;
                    else
                        req_done[i] <= 1'b1;
                end
            end
            if (wr) begin
                rr_ptr <= sel_next;
                if (rem_q[sel] == CNT_W'(sel_len)) begin
                    active[sel]   <= 1'b0;
                    req_done[sel] <= 1'b1;
                end
            end
        end
    end

    // Slot payload is only meaningful while ACTIVE, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (!active[i] && req_valid[i]) begin
                bank_q[i] <= req_bank[i];
                addr_q[i] <= req_addr[i];
                rem_q[i]  <= req_cnt[i];
            end
        end
        if (wr) begin
            addr_q[sel] <= addr_q[sel] + 10'(sel_len);
            rem_q[sel]  <= rem_q[sel] - CNT_W'(sel_len);
        end
    end

endmodule

// File: tb/tb_neighbor_req_issuer.sv
// Directed bench for neighbor_req_issuer: chunking, wrap, round-robin under
// backpressure, zero-count requests and asynchronous reset mid-request.
module tb_neighbor_req_issuer;

    logic             clk;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][1:0]  req_bank;
    logic [3:0][9:0]  req_addr;
    logic [3:0][7:0]  req_cnt;
    logic [3:0]       req_ready;
    logic [3:0]       req_done;
    logic [19:0]      wdata;
    logic             wfull;

    int checks;
    int errors;

    neighbor_req_issuer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bank  (req_bank),
        .req_addr  (req_addr),
        .req_cnt   (req_cnt),
        .req_ready (req_ready),
        .req_done  (req_done),
        .wdata     (wdata),
        .wfull     (wfull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] w(input logic [1:0] b, input logic [9:0] a,
                                      input logic [4:0] l, input logic [1:0] t);
        return {1'b1, b, a, l, t};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int pe, input logic [1:0] b, input logic [9:0] a,
                           input logic [7:0] c);
        req_valid[pe] = 1'b1;
        req_bank[pe]  = b;
        req_addr[pe]  = a;
        req_cnt[pe]   = c;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_bank  = '0;
        req_addr  = '0;
        req_cnt   = '0;
        wfull     = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        chk("rst_wdata", wdata, 20'h0);
        chk("rst_ready", 20'(req_ready), 20'hF);
        chk("rst_done",  20'(req_done), 20'h0);
        #2 reset = 1'b1;

        // Single short request
        tick();
        set_req(0, 2'd0, 10'd0, 8'd5);
        tick();
        req_valid = '0;
        chk("short_w0",    wdata, w(2'd0, 10'd0, 5'd5, 2'd0));
        chk("short_ready", 20'(req_ready), 20'hE);
        tick();
        chk("short_idle",  wdata, 20'h0);
        chk("short_done",  20'(req_done), 20'h1);
        chk("short_rdy2",  20'(req_ready), 20'hF);
        tick();
        chk("short_done0", 20'(req_done), 20'h0);

        // Chunking of a 70-neighbor request
        set_req(1, 2'd1, 10'd2, 8'd70);
        tick();
        req_valid = '0;
        chk("chunk_w0", wdata, w(2'd1, 10'd2, 5'd31, 2'd1));
        tick();
        chk("chunk_w1", wdata, w(2'd1, 10'd33, 5'd31, 2'd1));
        chk("chunk_nodone", 20'(req_done), 20'h0);
        tick();
        chk("chunk_w2", wdata, w(2'd1, 10'd64, 5'd8, 2'd1));
        chk("chunk_nodone2", 20'(req_done), 20'h0);
        tick();
        chk("chunk_idle", wdata, 20'h0);
        chk("chunk_done", 20'(req_done), 20'h2);
        tick();

        // Address wrap within bank 3
        set_req(2, 2'd3, 10'd1020, 8'd40);
        tick();
        req_valid = '0;
        chk("wrap_w0", wdata, w(2'd3, 10'd1020, 5'd31, 2'd2));
        tick();
        chk("wrap_w1", wdata, w(2'd3, 10'd27, 5'd9, 2'd2));
        tick();
        chk("wrap_done", 20'(req_done), 20'h4);
        chk("wrap_idle", wdata, 20'h0);

        // One-neighbor request on PE3 moves the pointer back to 0
        set_req(3, 2'd0, 10'd7, 8'd1);
        tick();
        req_valid = '0;
        chk("one_w0", wdata, w(2'd0, 10'd7, 5'd1, 2'd3));
        tick();
        chk("one_done", 20'(req_done), 20'h8);

        // Round-robin under backpressure
        wfull = 1'b1;
        set_req(0, 2'd0, 10'd100, 8'd62);
        set_req(3, 2'd2, 10'd5, 8'd31);
        tick();
        req_valid = '0;
        chk("stall_ready", 20'(req_ready), 20'h6);
        for (int c = 0; c < 4; c++) begin
            chk("stall_wdata", wdata, 20'h0);
            if (c < 3) tick();
        end
        wfull = 1'b0;
        #1;
        chk("rr_w0", wdata, w(2'd0, 10'd100, 5'd31, 2'd0));
        tick();
        chk("rr_w1", wdata, w(2'd2, 10'd5, 5'd31, 2'd3));
        tick();
        chk("rr_w2", wdata, w(2'd0, 10'd131, 5'd31, 2'd0));
        chk("rr_done3", 20'(req_done), 20'h8);
        tick();
        chk("rr_done0", 20'(req_done), 20'h1);
        chk("rr_idle", wdata, 20'h0);
        tick();

        // Zero-count request
        set_req(1, 2'd2, 10'd9, 8'd0);
        tick();
        req_valid = '0;
        chk("zero_wdata", wdata, 20'h0);
        chk("zero_done",  20'(req_done), 20'h2);
        chk("zero_ready", 20'(req_ready), 20'hF);
        tick();
        chk("zero_done0", 20'(req_done), 20'h0);

        // Reset in the middle of a long request (pointer is 1 here)
        set_req(0, 2'd1, 10'd0, 8'd100);
        tick();
        req_valid = '0;
        chk("mid_w0", wdata, w(2'd1, 10'd0, 5'd31, 2'd0));
        tick();
        chk("mid_w1", wdata, w(2'd1, 10'd31, 5'd31, 2'd0));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_wdata", wdata, 20'h0);
        chk("mid_rst_ready", 20'(req_ready), 20'hF);
        tick();
        #1 reset = 1'b1;
        tick();
        chk("post_wdata", wdata, 20'h0);
        chk("post_ready", 20'(req_ready), 20'hF);
        tick();
        chk("post_wdata2", wdata, 20'h0);
        chk("post_done", 20'(req_done), 20'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
